// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and state encoding for uart_tx/uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DATA_BITS        = 8;
    localparam int c_CLKS_PER_BIT_DEF = 521;   // 10 MHz / 19200 baud

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA_BURST = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter; pulses bit_end on the last clock of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = uart_pkg::c_CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_TERM) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bit_end = en && !clear && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N1 or 8E1, one byte per valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0
) (
    input  logic       tx_clk,
    input  logic       tx_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] c_LAST_BIT = 3'(c_DATA_BITS - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_next;
    logic [c_DATA_BITS-1:0] r_shreg;
    logic [c_DATA_BITS-1:0] w_shreg_next;
    logic [2:0]             r_bitpos;
    logic [2:0]             w_bitpos_next;
    logic                   r_parity;
    logic                   w_parity_next;
    logic                   r_tx_out;
    logic                   w_out_next;
    logic                   r_done;
    logic                   w_done_next;
    logic                   w_bit_end;
    logic                   w_idle;

    assign w_idle = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (tx_clk),
        .rst     (tx_rst),
        .clear   (w_idle),
        .en      (!w_idle),
        .bit_end (w_bit_end)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_bitpos_next = r_bitpos;
        w_parity_next = r_parity;
        w_done_next   = 1'b0;
        w_out_next    = 1'b1;

        case (r_state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    w_state_next  = START;
                    w_shreg_next  = tx_data;
                    w_parity_next = ^tx_data;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA_BURST;
                end
            end
            DATA_BURST: begin
                if (w_bit_end) begin
                    w_shreg_next = r_shreg >> 1;
                    if (r_bitpos == c_LAST_BIT) begin
                        w_bitpos_next = '0;
                        w_state_next  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bitpos_next = r_bitpos + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Line level is decoded from the next state so the registered output
        // changes on the same edge as the state it belongs to.
        case (w_state_next)
            START:      w_out_next = 1'b0;
            DATA_BURST: w_out_next = w_shreg_next[0];
            PARITY:     w_out_next = w_parity_next;
            default:    w_out_next = 1'b1;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitpos <= '0;
            r_parity <= 1'b0;
            r_tx_out <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_bitpos <= w_bitpos_next;
            r_parity <= w_parity_next;
            r_tx_out <= w_out_next;
            r_done   <= w_done_next;
        end
    end

    assign tx_ready = w_idle && !tx_rst;
    assign tx_out   = r_tx_out;
    assign tx_busy  = !w_idle;
    assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx with a loopback receiver monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [1:0] sel;

    always #5 clk = ~clk;

    logic v0, v1, v2;
    logic out0, rdy0, busy0, done0;
    logic out1, rdy1, busy1, done1;
    logic out2, rdy2, busy2, done2;

    assign v0 = valid && (sel == 2'd0);
    assign v1 = valid && (sel == 2'd1);
    assign v2 = valid && (sel == 2'd2);

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
        .tx_clk(clk), .tx_rst(rst), .tx_valid(v0), .tx_data(data),
        .tx_ready(rdy0), .tx_out(out0), .tx_busy(busy0), .tx_done(done0));

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
        .tx_clk(clk), .tx_rst(rst), .tx_valid(v1), .tx_data(data),
        .tx_ready(rdy1), .tx_out(out1), .tx_busy(busy1), .tx_done(done1));

    uart_tx #(.CLKS_PER_BIT(521), .PARITY_EN(0)) u_dut2 (
        .tx_clk(clk), .tx_rst(rst), .tx_valid(v2), .tx_data(data),
        .tx_ready(rdy2), .tx_out(out2), .tx_busy(busy2), .tx_done(done2));

    logic mon_line, mon_busy, mon_done, mon_ready, mon_par;
    int   mon_c;

    assign mon_line  = (sel == 2'd0) ? out0  : (sel == 2'd1) ? out1  : out2;
    assign mon_busy  = (sel == 2'd0) ? busy0 : (sel == 2'd1) ? busy1 : busy2;
    assign mon_done  = (sel == 2'd0) ? done0 : (sel == 2'd1) ? done1 : done2;
    assign mon_ready = (sel == 2'd0) ? rdy0  : (sel == 2'd1) ? rdy1  : rdy2;
    assign mon_par   = (sel == 2'd1);
    assign mon_c     = (sel == 2'd2) ? 521 : 4;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          frames_seen = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hs_cnt = 0;
    logic [8:0]  exp_q[$];
    int          starts[$];
    logic [10:0] last_cells = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (done0 || done1 || done2)) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!rst && ((v0 && rdy0) || (v1 && rdy1) || (v2 && rdy2)))
            hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Loopback receiver: every cycle of each bit cell must hold the same level.
    task automatic run_frame();
        int          n;
        int          c;
        logic [10:0] cells;
        logic        tbad;
        logic        bbad;
        logic        abort;
        logic [8:0]  e;
        c     = mon_c;
        n     = mon_par ? 11 : 10;
        cells = '0;
        tbad  = 1'b0;
        bbad  = 1'b0;
        abort = 1'b0;
        starts.push_back(cyc);
        for (int i = 0; i < n * c; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (rst) begin
                    abort = 1'b1;
                    break;
                end
            end
            if (i % c == 0) cells[i / c] = mon_line;
            else if (mon_line !== cells[i / c]) tbad = 1'b1;
            if (mon_busy !== 1'b1) bbad = 1'b1;
        end
        if (abort) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            frames_seen++;
            return;
        end
        @(negedge clk);
        check("done_pulse", mon_done, 1);
        check("busy_after_frame", mon_busy, 0);
        check("bit_timing", tbad, 0);
        check("busy_in_frame", bbad, 0);
        check("stop_bit", cells[n - 1], 1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", cells[8:1]);
        end else begin
            e = exp_q.pop_front();
            check("rx_byte", cells[8:1], e[7:0]);
            if (mon_par) check("parity_bit", cells[9], e[8]);
        end
        last_cells = cells;
        frames_seen++;
    endtask

    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !mon_line) run_frame();
            prev = mon_line;
        end
    end

    task automatic wait_ready(output int t);
        logic ok;
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (mon_ready && !rst) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
        check("ready_seen", ok, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic p, output int t);
        valid = 1'b1;
        data  = d;
        wait_ready(t);
        exp_q.push_back({p, d});
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 20000 && frames_seen < n; k++) @(negedge clk);
        check("frame_count", frames_seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_start(input int t);
        int s;
        check("start_seen", starts.size() > 0, 1);
        if (starts.size() > 0) begin
            s = starts.pop_front();
            check("start_latency", s - t, 1);
        end
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        int s1;
        int s2;
        int d0;
        int idle_bad;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        sel   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy0, 0);
        check("rst_out", out0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_out_521", out2, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 ||
                out1 !== 1'b1 || rdy1 !== 1'b1 || out2 !== 1'b1 || rdy2 !== 1'b1)
                idle_bad++;
        end
        check("idle20", idle_bad, 0);
        @(posedge clk);
        #1;

        // 8N1, 0xA5
        sel = 2'd0;
        send(8'hA5, 1'b0, t);
        wait_frames(1);
        check_start(t);
        check("a5_cells", last_cells, 11'h34A);
        check("a5_done_time", done_cyc - t, 41);

        // 8E1
        sel = 2'd1;
        send(8'hA5, 1'b0, t);
        wait_frames(2);
        check_start(t);
        check("a5p_cells", last_cells, 11'h54A);
        check("a5p_done_time", done_cyc - t, 45);
        send(8'h01, 1'b1, t);
        wait_frames(3);
        check_start(t);
        check("01p_cells", last_cells, 11'h602);
        check("01p_done_time", done_cyc - t, 45);

        // back-to-back with valid held
        sel   = 2'd0;
        valid = 1'b1;
        data  = 8'h55;
        wait_ready(t1);
        exp_q.push_back({1'b0, 8'h55});
        @(posedge clk);
        #1 data = 8'h0F;
        wait_ready(t2);
        check("b2b_in_done_cycle", mon_done, 1);
        exp_q.push_back({1'b0, 8'h0F});
        @(posedge clk);
        #1 valid = 1'b0;
        check("b2b_accept_gap", t2 - t1, 41);
        wait_frames(5);
        check("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) begin
            s1 = starts.pop_front();
            s2 = starts.pop_front();
            check("b2b_start1", s1 - t1, 1);
            check("b2b_start_gap", s2 - s1, 41);
        end
        check("0f_cells", last_cells, 11'h21E);

        // tx_data churns and valid stays high while busy
        valid = 1'b1;
        data  = 8'hC3;
        wait_ready(t);
        exp_q.push_back({1'b0, 8'hC3});
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 data = 8'($urandom);
        end
        valid = 1'b0;
        wait_frames(6);
        check_start(t);
        check("hold_done_time", done_cyc - t, 41);

        // reset during data bit 3
        send(8'hE7, 1'b0, t);
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_out", out0, 1);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_ready", rdy0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_frame_aborted", frames_seen, 7);
        check("rst_byte_lost", exp_q.size(), 0);
        if (starts.size() > 0) void'(starts.pop_front());
        @(posedge clk);
        #1;
        send(8'h3C, 1'b0, t);
        wait_frames(8);
        check_start(t);
        check("3c_cells", last_cells, 11'h278);
        check("3c_done_time", done_cyc - t, 41);

        // 521 clocks per bit
        sel = 2'd2;
        send(8'h96, 1'b0, t);
        wait_frames(9);
        check_start(t);
        check("96_cells", last_cells, 11'h32C);
        check("96_done_time", done_cyc - t, 5211);

        check("done_total", done_cnt, 8);
        check("handshakes", hs_cnt, 9);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the serialising counterpart of the team's uart_rx.
- Accepts one byte per valid/ready handshake and drives the serial line: start bit (0), 8 data bits LSB first, optional even parity, one stop bit (1).
- Bit period is a fixed number of clocks, CLKS_PER_BIT = f_clk / baud.
- Sits between the byte-producing logic and the serial pin that feeds a remote uart_rx.

Parameters:
- CLKS_PER_BIT, 521, clocks per serial bit (10 MHz / 19200 baud); legal range >= 2.
- PARITY_EN, 0, 0 = no parity bit; 1 = even parity bit inserted between data and stop.

Ports:
- tx_clk  input  1  system clock; all logic on its rising edge.
- tx_rst  input  1  reset; one clock, reset is synchronous and active-high.
- tx_valid  input  1  tx_data holds a byte to send.
- tx_data  input  8  byte to transmit; sampled only at handshake.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (cycle after tx_rst sampled high): tx_out=1, tx_ready=0 while tx_rst high, then 1; tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- Handshake: a transfer occurs on any rising edge where tx_valid && tx_ready. tx_data is copied into an internal shift register at that edge. Later changes to tx_data have no effect on the frame in flight.
- tx_ready = (state==IDLE) && !tx_rst. It is combinational from state; it never depends on tx_valid.
- States and transitions:
  - IDLE: tx_out=1. On a transfer -> START.
  - START: tx_out=0 for exactly CLKS_PER_BIT cycles -> DATA_BURST.
  - DATA_BURST: tx_out=shreg[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and increment bitpos (0..7). After bit 7 -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx_out = XOR of the 8 accepted bits (even parity) for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles -> IDLE, with tx_done=1 in the first IDLE cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1; at terminal count it clears to 0 and the bit advances. The counter must not saturate or wrap early (e.g. 521 needs 10 bits).
- bitpos is 3 bits; it is compared, not allowed to wrap, when leaving DATA_BURST.
- Timing (accept edge ends cycle T, C=CLKS_PER_BIT, N=10 without parity or 11 with parity):
  - start bit occupies cycles T+1..T+C;
  - stop bit ends at cycle T+N*C;
  - tx_done=1 and tx_ready=1 in cycle T+N*C+1.
- Back-to-back frames: a transfer in the tx_done cycle is legal. The next start bit begins at T+N*C+2, so the line is always high for at least C+1 cycles between frames.
- tx_out is registered (glitch-free), not decoded from state combinationally.
- tx_valid asserted while busy: ignored (tx_ready=0); the byte is held by the producer.
- Reset mid-frame: the frame is abandoned. tx_out=1 the next cycle, no tx_done, the state returns to IDLE, and the in-flight byte is lost.
- tx_rst and tx_valid high in the same cycle: reset wins; no transfer.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding IDLE/START/DATA_BURST/PARITY/STOP, 3 bits; uart_rx migrates to the same package later;
  - DATA_BITS=8;
  - default CLKS_PER_BIT=521.
- One natural sub-module, uart_baud_cnt: parameter CLKS_PER_BIT; inputs clk, rst, clear, en; output bit_end pulse. Reusable by uart_rx.
- The FSM and shift register remain in uart_tx.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset, then idle 20 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- Send 0xA5, PARITY_EN=0 -> tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_done pulse at cycle T+41; tx_busy high for cycles T+1..T+40.
- PARITY_EN=1:
  - send 0xA5 -> parity bit 0, tx_done at T+45;
  - send 0x01 -> parity bit 1.
- Back-to-back: hold tx_valid with 0x55 then 0x0F -> second accepted in the tx_done cycle; exactly 5 high cycles between the data bits of frame 1 and the start bit of frame 2; the loopback uart_rx model returns 0x55, 0x0F.
- Change tx_data every cycle during a frame, and hold tx_valid high while busy -> transmitted byte equals the value at the handshake; no extra transfer occurs.
- Assert tx_rst during bit 3 of a frame -> tx_out=1 the next cycle, no tx_done, the next send of 0x3C is transmitted correctly.
- CLKS_PER_BIT=521: send 0x96 -> each bit is exactly 521 cycles; the loopback uart_rx receives 0x96.
